// File: rtl/pattern_cfg_sequencer.sv
// Avalon-MM master that programs the pattern-match control registers on a start pulse:
// disable, write key words, optionally read back and compare, then enable.
module pattern_cfg_sequencer #(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned PAT_WIDTH  = 3,
  parameter int unsigned PAT_SIZE   = PAT_WIDTH * REG_WIDTH,
  parameter bit          VERIFY     = 1'b1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic [PAT_SIZE-1:0]   cfg_pattern_i,
  input  logic                  cfg_enable_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            err_o,
  output logic [ADDR_WIDTH-1:0] amm_address_o,
  output logic                  amm_write_o,
  output logic [REG_WIDTH-1:0]  amm_writedata_o,
  output logic                  amm_read_o,
  input  logic                  amm_waitrequest_i,
  input  logic [REG_WIDTH-1:0]  amm_readdata_i,
  input  logic                  amm_readdatavalid_i
);

  localparam int unsigned KW = $clog2(PAT_WIDTH + 1);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrMismatch = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StWrDis, StWrPat, StRdReq, StRdWait, StWrEn, StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             err_q, err_d;
  logic [PAT_SIZE-1:0]    pat_q, pat_d;
  logic                   en_q, en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic                   read_q, read_d;
  logic                   accept;
  logic                   mismatch;
  logic [KW-1:0]          k_inc;
  logic [REG_WIDTH-1:0]   words [PAT_WIDTH+1];

  // Word 1 is the most significant slice of the pattern (first word in [0:PAT_SIZE-1] order).
  always_comb begin
    words[0] = '0;
    for (int unsigned j = 1; j <= PAT_WIDTH; j++) begin
      words[j] = pat_q[PAT_SIZE - REG_WIDTH * j +: REG_WIDTH];
    end
  end

  assign accept = (write_q | read_q) & ~amm_waitrequest_i;
  assign k_inc  = k_q + KW'(1);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pat_d    = pat_q;
    en_d     = en_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    read_d   = read_q;
    mismatch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_start_i) begin
          pat_d   = cfg_pattern_i;
          en_d    = cfg_enable_i;
          err_d   = ErrNone;
          state_d = StWrDis;
          addr_d  = '0;
          wdata_d = '0;
          write_d = 1'b1;
        end
      end
      StWrDis: begin
        if (accept) begin
          state_d = StWrPat;
          k_d     = KW'(1);
          addr_d  = ADDR_WIDTH'(1);
          wdata_d = words[1];
        end
      end
      StWrPat: begin
        if (accept) begin
          if (k_q == KW'(PAT_WIDTH)) begin
            if (VERIFY) begin
              state_d = StRdReq;
              k_d     = KW'(1);
              addr_d  = ADDR_WIDTH'(1);
              write_d = 1'b0;
              read_d  = 1'b1;
            end else begin
              state_d = StWrEn;
              addr_d  = '0;
              wdata_d = {{(REG_WIDTH-1){1'b0}}, en_q};
            end
          end else begin
            k_d     = k_inc;
            addr_d  = ADDR_WIDTH'(k_inc);
            wdata_d = words[k_inc];
          end
        end
      end
      StRdReq: begin
        if (accept) begin
          read_d  = 1'b0;
          cnt_d   = '0;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (amm_readdatavalid_i) begin
          mismatch = amm_readdata_i != words[k_q];
          if (mismatch && err_q == ErrNone) err_d = ErrMismatch;
          if (k_q == KW'(PAT_WIDTH)) begin
            // Any error leaves the matcher disabled.
            if (err_d != ErrNone) begin
              state_d = StDone;
            end else begin
              state_d = StWrEn;
              addr_d  = '0;
              wdata_d = {{(REG_WIDTH-1){1'b0}}, en_q};
              write_d = 1'b1;
            end
          end else begin
            state_d = StRdReq;
            k_d     = k_inc;
            addr_d  = ADDR_WIDTH'(k_inc);
            read_d  = 1'b1;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          if (err_q == ErrNone) err_d = ErrTimeout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWrEn: begin
        if (accept) begin
          write_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= ErrNone;
      pat_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pat_q   <= pat_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      read_q  <= read_d;
    end
  end

  assign busy_o          = state_q != StIdle;
  assign done_o          = state_q == StDone;
  assign err_o           = err_q;
  assign amm_address_o   = addr_q;
  assign amm_writedata_o = wdata_q;
  assign amm_write_o     = write_q;
  assign amm_read_o      = read_q;

endmodule

// File: tb/tb_pattern_cfg_sequencer.sv
// Bench for pattern_cfg_sequencer: one VERIFY=0 and one VERIFY=1 instance, each on its own
// Avalon-MM slave model with programmable stall, readback corruption and dropped responses.
module tb_pattern_cfg_sequencer;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        start = '0;
  logic [1:0]        en = '0;
  logic [1:0][95:0]  pat = '0;
  logic [1:0]        busy, done, wr, rd, wq;
  logic [1:0]        rdv = '0;
  logic [1:0][1:0]   err;
  logic [1:0][3:0]   addr;
  logic [1:0][31:0]  wd;
  logic [1:0][31:0]  rdd = '0;

  pattern_cfg_sequencer #(.VERIFY(1'b0), .TIMEOUT(TO)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(start[0]), .cfg_pattern_i(pat[0]),
    .cfg_enable_i(en[0]), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
    .amm_address_o(addr[0]), .amm_write_o(wr[0]), .amm_writedata_o(wd[0]),
    .amm_read_o(rd[0]), .amm_waitrequest_i(wq[0]), .amm_readdata_i(rdd[0]),
    .amm_readdatavalid_i(rdv[0])
  );

  pattern_cfg_sequencer #(.VERIFY(1'b1), .TIMEOUT(TO)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(start[1]), .cfg_pattern_i(pat[1]),
    .cfg_enable_i(en[1]), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
    .amm_address_o(addr[1]), .amm_write_o(wr[1]), .amm_writedata_o(wd[1]),
    .amm_read_o(rd[1]), .amm_waitrequest_i(wq[1]), .amm_readdata_i(rdd[1]),
    .amm_readdatavalid_i(rdv[1])
  );

  // Slave configuration (written by the stimulus only)
  logic [3:0] bad [2] = '{4'd0, 4'd0};
  bit         drop [2] = '{1'b0, 1'b0};
  int         stall_n [2] = '{0, 0};

  // Slave/monitor state (written by the slave process only)
  int          cyc = 0;
  int          stc [2] = '{0, 0};
  int          wcnt [2] = '{0, 0};
  int          both_err [2] = '{0, 0};
  int          stab_err [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};
  logic [1:0]  err_done [2];
  logic        busy_done [2];
  logic        busy_post [2];
  logic        done_prev [2] = '{1'b0, 1'b0};
  logic        hold_prev [2] = '{1'b0, 1'b0};
  logic [37:0] held [2];
  logic [31:0] mem [2][16];
  logic [35:0] wlog [2][512];

  always_comb begin
    for (int i = 0; i < 2; i++) wq[i] = (wr[i] | rd[i]) && (stc[i] < stall_n[i]);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      rdv[i] <= 1'b0;
      stc[i] <= ((wr[i] | rd[i]) && wq[i]) ? stc[i] + 1 : 0;
      if (wr[i] && !wq[i]) begin
        mem[i][addr[i]] <= wd[i];
        if (wcnt[i] < 512) wlog[i][wcnt[i]] <= {addr[i], wd[i]};
        wcnt[i] <= wcnt[i] + 1;
      end
      if (rd[i] && !wq[i] && !drop[i]) begin
        rdv[i] <= 1'b1;
        rdd[i] <= mem[i][addr[i]] ^ ((addr[i] == bad[i]) ? 32'h1 : 32'h0);
      end
      if (wr[i] && rd[i]) both_err[i] <= both_err[i] + 1;
      if (hold_prev[i] && ({addr[i], wd[i], wr[i], rd[i]} !== held[i]))
        stab_err[i] <= stab_err[i] + 1;
      hold_prev[i] <= (wr[i] | rd[i]) && wq[i];
      held[i]      <= {addr[i], wd[i], wr[i], rd[i]};
      if (done[i]) begin
        done_cnt[i]  <= done_cnt[i] + 1;
        done_cyc[i]  <= cyc;
        err_done[i]  <= err[i];
        busy_done[i] <= busy[i];
      end
      if (done_prev[i]) busy_post[i] <= busy[i];
      done_prev[i] <= done[i];
    end
  end

  int nchk = 0, npass = 0, nfail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: expected write list, error code and done latency from the sequencing rules.
  task automatic run(input int i, input logic [95:0] p, input logic e, input logic [3:0] b,
                     input bit dr, input int s, input bit mid_start);
    logic [35:0] ew [5];
    int ne, elat, bw, bd, bs, bb, t0, t;
    logic [1:0] eerr;
    bit v;
    v    = (i == 1);
    eerr = (v && dr) ? 2'b10 : (v && b >= 4'd1 && b <= 4'd3) ? 2'b01 : 2'b00;
    ew[0] = 36'h0;
    for (int k = 1; k <= 3; k++) ew[k] = {4'(k), p[96 - 32 * k +: 32]};
    ne = 4;
    if (eerr == 2'b00) begin
      ew[4] = {4'd0, 31'd0, e};
      ne = 5;
    end
    elat = 4 * (1 + s);
    if (v) elat += dr ? (1 + s) + TO : 3 * (2 + s);
    if (eerr == 2'b00) elat += 1 + s;
    elat += 1;

    bad[i] = b; drop[i] = dr; stall_n[i] = s;
    bw = wcnt[i]; bd = done_cnt[i]; bs = stab_err[i]; bb = both_err[i];
    @(negedge clk);
    pat[i] = p; en[i] = e; start[i] = 1'b1; t0 = cyc;
    @(negedge clk);
    start[i] = 1'b0; pat[i] = {$urandom, $urandom, $urandom}; en[i] = ~e;
    if (mid_start) begin
      repeat (2) @(negedge clk);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
    end
    t = 0;
    while (done_cnt[i] == bd && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("done_count", 64'(done_cnt[i] - bd), 64'd1);
    check("done_latency", 64'(done_cyc[i] - t0), 64'(elat));
    check("err_at_done", 64'(err_done[i]), 64'(eerr));
    check("busy_at_done", 64'(busy_done[i]), 64'd1);
    check("busy_after_done", 64'(busy_post[i]), 64'd0);
    check("write_count", 64'(wcnt[i] - bw), 64'(ne));
    for (int k = 0; k < ne && k < wcnt[i] - bw; k++) check("write_beat", 64'(wlog[i][bw + k]), 64'(ew[k]));
    check("stable_while_stalled", 64'(stab_err[i] - bs), 64'd0);
    check("rd_wr_exclusive", 64'(both_err[i] - bb), 64'd0);
  endtask

  initial begin
    int bd;
    logic [95:0] rp;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check("reset_outputs", 64'({busy[i], done[i], err[i], wr[i], rd[i], addr[i], wd[i]}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 96'h11111111_22222222_33333333, 1'b1, 4'd0, 1'b0, 0, 1'b0);
    run(0, 96'h11111111_22222222_33333333, 1'b1, 4'd0, 1'b0, 3, 1'b0);
    run(1, 96'h11111111_22222222_33333333, 1'b1, 4'd2, 1'b0, 0, 1'b0);
    run(1, {$urandom, $urandom, $urandom}, 1'b1, 4'd0, 1'b1, 0, 1'b0);
    run(0, {$urandom, $urandom, $urandom}, 1'b1, 4'd0, 1'b0, 0, 1'b1);
    run(1, {$urandom, $urandom, $urandom}, 1'b0, 4'd0, 1'b0, 0, 1'b1);

    // Reset during the pattern writes aborts with no done pulse.
    bd = done_cnt[0];
    @(negedge clk);
    pat[0] = {$urandom, $urandom, $urandom}; en[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("wr_pat_busy", 64'({busy[0], wr[0]}), 64'h3);
    rst = 1'b1;
    #1;
    check("reset_mid_outputs", 64'({busy[0], done[0], err[0], wr[0], rd[0], addr[0], wd[0]}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_done_after_reset", 64'(done_cnt[0] - bd), 64'd0);
    run(0, {$urandom, $urandom, $urandom}, 1'b1, 4'd0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      rp = {$urandom, $urandom, $urandom};
      run(n % 2, rp, 1'($urandom), 4'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
          int'($urandom_range(0, 2)), 1'b0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
